// File: rtl/simple_proc_pkg.sv
// Shared types and defaults for the processor/loader memory arbiter.
package simple_proc_pkg;
   localparam int WIDTH_DEF     = 32;
   localparam int ADDRSIZE_DEF  = 8;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} arb_state_t;
   typedef enum logic {PORT_A, PORT_B} port_id_t;
endpackage

// File: rtl/arb_pick.sv
// Combinational owner choice for a contested or fresh arbitration decision.
// ARB_FIXED_PRIO_EN selects fixed priority to port A; default is round-robin.
module arb_pick
   import simple_proc_pkg::*;
(
   input  logic     a_req,
   input  logic     b_req,
   input  port_id_t last_owner,
   output port_id_t winner
);

   always_comb begin
      winner = last_owner;
`ifdef ARB_FIXED_PRIO_EN
      if (a_req)      winner = PORT_A;
      else if (b_req) winner = PORT_B;
`else
      if (a_req && b_req) winner = (last_owner == PORT_A) ? PORT_B : PORT_A;
      else if (a_req)     winner = PORT_A;
      else if (b_req)     winner = PORT_B;
`endif
   end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Two-port (processor A / loader B) arbiter onto one single-port memory with burst limit.
// Define ARB_FIXED_PRIO_EN for fixed priority to port A instead of round-robin.
//
// state | meaning
// IDLE  | no owner, memory disabled
// OWN_A | port A drives the memory, a_gnt follows a_req
// OWN_B | port B drives the memory, b_gnt follows b_req
module proc_mem_arbiter
   import simple_proc_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int ADDRSIZE  = ADDRSIZE_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_req,
   input  logic                a_we,
   input  logic [ADDRSIZE-1:0] a_addr,
   input  logic [WIDTH-1:0]    a_wdata,
   input  logic                b_req,
   input  logic                b_we,
   input  logic [ADDRSIZE-1:0] b_addr,
   input  logic [WIDTH-1:0]    b_wdata,
   output logic                a_gnt,
   output logic                b_gnt,
   output logic                a_rvalid,
   output logic                b_rvalid,
   output logic [WIDTH-1:0]    a_rdata,
   output logic [WIDTH-1:0]    b_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDRSIZE-1:0] mem_addr,
   output logic [WIDTH-1:0]    mem_wdata,
   input  logic [WIDTH-1:0]    mem_rdata
);

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   arb_state_t state, state_nxt;
   port_id_t   last_owner, last_nxt, pick;
   logic [3:0] cnt, cnt_nxt, cnt_inc;

   arb_pick u_pick (
      .a_req      (a_req),
      .b_req      (b_req),
      .last_owner (last_owner),
      .winner     (pick)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last_owner;
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cnt_inc   = (cnt >= MAX_B) ? cnt : cnt + 4'd1;
      unique case (state)
         IDLE: begin
            if (a_req || b_req) begin
               state_nxt = (pick == PORT_A) ? OWN_A : OWN_B;
               last_nxt  = pick;
               cnt_nxt   = '0;
            end
         end
         OWN_A: begin
            a_gnt     = a_req;
            mem_en    = a_req;
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            if (!a_req) begin
               state_nxt = b_req ? OWN_B : IDLE;
               if (b_req) begin
                  last_nxt = PORT_B;
                  cnt_nxt  = '0;
               end
            end else begin
               cnt_nxt = cnt_inc;
               // Limit reached: yield only if the picker hands the slot to B
               if (cnt_inc >= MAX_B && b_req && pick == PORT_B) begin
                  state_nxt = OWN_B;
                  last_nxt  = PORT_B;
                  cnt_nxt   = '0;
               end
            end
         end
         OWN_B: begin
            b_gnt     = b_req;
            mem_en    = b_req;
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            if (!b_req) begin
               state_nxt = a_req ? OWN_A : IDLE;
               if (a_req) begin
                  last_nxt = PORT_A;
                  cnt_nxt  = '0;
               end
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc >= MAX_B && a_req && pick == PORT_A) begin
                  state_nxt = OWN_A;
                  last_nxt  = PORT_A;
                  cnt_nxt   = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_owner <= PORT_B;
         a_rvalid   <= 1'b0;
         b_rvalid   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_owner <= last_nxt;
         a_rvalid   <= a_gnt & ~a_we;
         b_rvalid   <= b_gnt & ~b_we;
      end
   end

   assign a_rdata = mem_rdata;
   assign b_rdata = mem_rdata;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Self-checking bench for proc_mem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_proc_mem_arbiter;

   localparam int W  = 32;
   localparam int AW = 8;
   localparam int MB = 4;

   logic          clk, rst;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [W-1:0]  a_wdata, b_wdata;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [W-1:0]  a_rdata, b_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata;

   logic [W-1:0]  mem [256];

   int checks = 0;
   int errors = 0;

   proc_mem_arbiter #(.WIDTH(W), .ADDRSIZE(AW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
      .a_rdata(a_rdata), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] init_word(input int a);
      if (a == 5) return 32'h0000_1234;
      return 32'hA500_0000 ^ (32'(a) * 32'h0001_0003);
   endfunction

   // Registered single-port memory model, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1;
      cyc();
      rst = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      a_req = 1; a_we = 1; a_addr = 8'h11; a_wdata = 32'h1111_1111;
      b_req = 1; b_we = 0; b_addr = 8'h22; b_wdata = 32'h2222_2222;
      cyc();
      cyc();
      checks++;
      if ({a_gnt, b_gnt, mem_en, mem_we, a_rvalid, b_rvalid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got gnt=%b%b en=%b we=%b rv=%b%b exp all 0",
                  a_gnt, b_gnt, mem_en, mem_we, a_rvalid, b_rvalid);
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_bus got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
      end
      rst = 0;
      idle_inputs();
      cyc();
   endtask

   task automatic test_single_read;
      do_reset();
      a_req = 1; a_we = 0; a_addr = 8'h05;
      #1;
      checks++;
      if (a_gnt !== 1'b0 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got a_gnt=%b mem_en=%b exp 0 0", a_gnt, mem_en);
      end
      cyc();
      checks++;
      if ({a_gnt, b_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 8'h05) begin
         errors++;
         $display("FAIL single_beat got gnt=%b%b en=%b we=%b addr=%h exp 10 1 0 05",
                  a_gnt, b_gnt, mem_en, mem_we, mem_addr);
      end
      cyc();
      a_req = 0;
      #1;
      checks++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'h1234 || b_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL single_rvalid got a_rv=%b a_rdata=%h b_rv=%b exp 1 00001234 0",
                  a_rvalid, a_rdata, b_rvalid);
      end
      cyc();
      checks++;
      if (a_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL single_rvalid_pulse got a_rv=%b exp 0", a_rvalid);
      end
   endtask

   task automatic test_write_b;
      do_reset();
      b_req = 1; b_we = 1; b_addr = 8'hFF; b_wdata = 32'hDEAD_BEEF;
      cyc();
      checks++;
      if ({b_gnt, a_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 8'hFF ||
          mem_wdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_b_beat got gnt b/a=%b%b en=%b we=%b addr=%h wdata=%h exp 10 1 1 ff deadbeef",
                  b_gnt, a_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      cyc();
      b_req = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_b_no_rvalid got b_rv=%b exp 0", b_rvalid);
         end
         cyc();
      end
      checks++;
      if (mem[255] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_b_mem got %h exp deadbeef", mem[255]);
      end
   endtask

   task automatic test_switch;
      do_reset();
      a_req = 1; a_we = 0; a_addr = 8'h03;
      b_req = 1; b_we = 0; b_addr = 8'h04;
      cyc();
      checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL switch_a_first got gnt=%b%b exp 10", a_gnt, b_gnt);
      end
      cyc();
      a_req = 0;
      #1;
      checks++;
      if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || a_rdata !== init_word(3)) begin
         errors++;
         $display("FAIL switch_a_rvalid got a_rv=%b b_rv=%b data=%h exp 1 0 %h",
                  a_rvalid, b_rvalid, a_rdata, init_word(3));
      end
      cyc();
      checks++;
      if ({a_gnt, b_gnt, a_rvalid} !== 3'b010) begin
         errors++;
         $display("FAIL switch_b_owns got gnt=%b%b a_rv=%b exp 01 0", a_gnt, b_gnt, a_rvalid);
      end
      cyc();
      b_req = 0;
      #1;
      checks++;
      if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || b_rdata !== init_word(4)) begin
         errors++;
         $display("FAIL switch_b_rvalid got b_rv=%b a_rv=%b data=%h exp 1 0 %h",
                  b_rvalid, a_rvalid, b_rdata, init_word(4));
      end
      cyc();
   endtask

   task automatic test_reset_midburst;
      do_reset();
      b_req = 1; b_we = 0; b_addr = 8'h09;
      cyc();
      rst = 1;
      cyc();
      checks++;
      if ({a_gnt, b_gnt, mem_en, a_rvalid, b_rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_midburst got gnt=%b%b en=%b rv=%b%b exp all 0",
                  a_gnt, b_gnt, mem_en, a_rvalid, b_rvalid);
      end
      rst = 0;
      b_req = 0;
      cyc();
   endtask

   // A requests a_total reads (none during cycle gap), B requests b_total reads; expected
   // grant bitmaps ea/eb are indexed by cycle number after reset.
   task automatic test_pattern(input string name, input int a_total, input int b_total,
                               input int gap, input logic [15:0] ea, input logic [15:0] eb,
                               input int n);
      int  a_done = 0, b_done = 0;
      bit  prev_a = 0, prev_b = 0;
      logic [AW-1:0] prev_a_addr = '0, prev_b_addr = '0;
      do_reset();
      for (int i = 0; i <= n; i++) begin
         a_req = (i < n) && (a_done < a_total) && (i != gap);
         b_req = (i < n) && (b_done < b_total);
         a_we = 0; b_we = 0;
         a_addr = 8'h40 + 8'(a_done);
         b_addr = 8'h80 + 8'(b_done);
         #1;
         if (i < n) begin
            checks++;
            if (a_gnt !== ea[i] || b_gnt !== eb[i]) begin
               errors++;
               $display("FAIL %s_gnt cycle %0d got %b%b exp %b%b", name, i, a_gnt, b_gnt, ea[i], eb[i]);
            end
         end
         checks++;
         if (a_rvalid !== prev_a || b_rvalid !== prev_b) begin
            errors++;
            $display("FAIL %s_rvalid cycle %0d got %b%b exp %b%b", name, i, a_rvalid, b_rvalid, prev_a, prev_b);
         end
         if (prev_a) begin
            checks++;
            if (a_rdata !== init_word(int'(prev_a_addr))) begin
               errors++;
               $display("FAIL %s_a_rdata cycle %0d got %h exp %h", name, i, a_rdata, init_word(int'(prev_a_addr)));
            end
         end
         if (prev_b) begin
            checks++;
            if (b_rdata !== init_word(int'(prev_b_addr))) begin
               errors++;
               $display("FAIL %s_b_rdata cycle %0d got %h exp %h", name, i, b_rdata, init_word(int'(prev_b_addr)));
            end
         end
         prev_a = (i < n) && ea[i];
         prev_b = (i < n) && eb[i];
         prev_a_addr = a_addr;
         prev_b_addr = b_addr;
         if (prev_a) a_done++;
         if (prev_b) b_done++;
         cyc();
      end
      idle_inputs();
   endtask

   task automatic test_burst_limit;
`ifdef ARB_FIXED_PRIO_EN
      test_pattern("burst", 6, 3, -1, 16'h007E, 16'h0700, 12);
`else
      test_pattern("burst", 6, 3, -1, 16'h061E, 16'h00E0, 12);
`endif
   endtask

   task automatic test_contention;
`ifdef ARB_FIXED_PRIO_EN
      test_pattern("contend", 99, 99, 10, 16'h83FE, 16'h7800, 16);
`else
      test_pattern("contend", 99, 99, 10, 16'h821E, 16'h79E0, 16);
`endif
   endtask

   function automatic int pick_port(input bit ar, input bit br, input int last);
`ifdef ARB_FIXED_PRIO_EN
      if (ar) return 1;
      if (br) return 2;
      return 0;
`else
      if (ar && br) return 3 - last;
      if (ar) return 1;
      if (br) return 2;
      return 0;
`endif
   endfunction

   task automatic test_random;
      int owner = 0, beats = 0, last = 2;
      bit pa = 0, pb = 0, ga, gb, my, oth;
      bit erv_a = 0, erv_b = 0, nrv_a, nrv_b;
      logic [W-1:0] erd_a = '0, erd_b = '0, nrd_a, nrd_b;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!pa && $urandom_range(0, 3) != 0) begin
            pa = 1; a_we = 1'($urandom_range(0, 1)); a_addr = 8'($urandom); a_wdata = $urandom;
         end
         if (!pb && $urandom_range(0, 2) != 0) begin
            pb = 1; b_we = 1'($urandom_range(0, 1)); b_addr = 8'($urandom); b_wdata = $urandom;
         end
         a_req = pa; b_req = pb;
         #1;
         ga = (owner == 1) && a_req;
         gb = (owner == 2) && b_req;
         checks++;
         if (a_gnt !== ga || b_gnt !== gb || mem_en !== (ga | gb)) begin
            errors++;
            $display("FAIL rand_gnt cycle %0d got gnt=%b%b en=%b exp %b%b %b", c, a_gnt, b_gnt, mem_en, ga, gb, ga | gb);
         end
         checks++;
         if (a_rvalid !== erv_a || b_rvalid !== erv_b) begin
            errors++;
            $display("FAIL rand_rvalid cycle %0d got %b%b exp %b%b", c, a_rvalid, b_rvalid, erv_a, erv_b);
         end
         if (erv_a || erv_b) begin
            checks++;
            if ((erv_a && a_rdata !== erd_a) || (erv_b && b_rdata !== erd_b)) begin
               errors++;
               $display("FAIL rand_rdata cycle %0d got a=%h b=%h exp a=%h b=%h", c, a_rdata, b_rdata, erd_a, erd_b);
            end
         end
         if (ga || gb) begin
            checks++;
            if (mem_addr !== (ga ? a_addr : b_addr) || mem_we !== (ga ? a_we : b_we) ||
                (mem_we && mem_wdata !== (ga ? a_wdata : b_wdata))) begin
               errors++;
               $display("FAIL rand_bus cycle %0d got addr=%h we=%b wdata=%h", c, mem_addr, mem_we, mem_wdata);
            end
         end
         nrv_a = ga && !a_we && !rst;
         nrv_b = gb && !b_we && !rst;
         nrd_a = mem[a_addr];
         nrd_b = mem[b_addr];
         if (rst) begin
            owner = 0; beats = 0; last = 2;
         end else if (owner == 0) begin
            if (a_req || b_req) begin
               owner = pick_port(a_req, b_req, last); beats = 0; last = owner;
            end
         end else begin
            my  = (owner == 1) ? a_req : b_req;
            oth = (owner == 1) ? b_req : a_req;
            if (!my) begin
               if (oth) begin owner = 3 - owner; beats = 0; last = owner; end
               else owner = 0;
            end else begin
               beats = (beats < MB) ? beats + 1 : MB;
               if (beats == MB && oth && pick_port(a_req, b_req, last) == 3 - owner) begin
                  owner = 3 - owner; beats = 0; last = owner;
               end
            end
         end
         if (ga) pa = 0;
         if (gb) pb = 0;
         cyc();
         erv_a = nrv_a; erv_b = nrv_b; erd_a = nrd_a; erd_b = nrd_b;
      end
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      mem_rdata = '0;
      rst = 1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_write_b();
      test_switch();
      test_reset_midburst();
      test_burst_limit();
      test_contention();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
